// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - time-multiplexed 7-segment scanner with blink, decimal-point and anti-ghost blanking
module seg_scan_display #(
    parameter int NUM_DIGITS     = 4,
    parameter int DISP_WIDTH     = 8,
    parameter int CLK_DIV_PERIOD = 125000,
    parameter int BLANK_CYCLES   = 2,
    parameter int BLINK_FRAMES   = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    show,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   digit_valid,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [DISP_WIDTH-1:0]   disps,
    output logic [7:0]              digital_leds,
    output logic                    frame_start
);

    localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(CLK_DIV_PERIOD);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] POS_LAST   = PW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV_PERIOD - 1);
    localparam logic [CW-1:0] CNT_EN     = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         pos_q, pos_d, pos_nxt;
    logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic                  lit_q, lit_d, lit_nxt;
    logic [DISP_WIDTH-1:0] disps_q, disps_d;
    logic [7:0]            leds_q, leds_d, glyph_nxt;
    logic                  frame_start_q, frame_start_d;
    logic                  tick;
    logic [3:0]            nib_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3f;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5b;  4'h3: hex7 = 7'h4f;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6d;  4'h6: hex7 = 7'h7d;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7f;  4'h9: hex7 = 7'h6f;  4'ha: hex7 = 7'h77;  4'hb: hex7 = 7'h7c;
            4'hc: hex7 = 7'h39;  4'hd: hex7 = 7'h5e;  4'he: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        tick      = (cnt_q == CNT_LAST);
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        pos_nxt   = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        nib_nxt   = digit_data[{pos_nxt, 2'b00} +: 4];
        lit_nxt   = digit_valid[pos_nxt] & ~(blink_mask[pos_nxt] & blink_phase_q);
        if (!digit_valid[pos_nxt])
            glyph_nxt = 8'h00;
        else
            glyph_nxt = {dp_mask[pos_nxt], show ? hex7(nib_nxt) : 7'h40};

        pos_d         = pos_q;
        leds_d        = leds_q;
        disps_d       = disps_q;
        lit_d         = lit_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        frame_start_d = 1'b0;

        if (tick) begin
            // Inputs are captured only here; the slot then shows a stable snapshot.
            pos_d   = pos_nxt;
            leds_d  = glyph_nxt;
            lit_d   = lit_nxt;
            disps_d = '1;
            if (BLANK_CYCLES == 0)
                disps_d[pos_nxt] = ~lit_nxt;
            if (pos_nxt == '0) begin
                frame_start_d = 1'b1;
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
        end else if ((BLANK_CYCLES > 0) && (cnt_q == CNT_EN)) begin
            disps_d        = '1;
            disps_d[pos_q] = ~lit_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            pos_q         <= POS_LAST;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            lit_q         <= 1'b0;
            disps_q       <= '1;
            leds_q        <= 8'h00;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            pos_q         <= pos_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            lit_q         <= lit_d;
            disps_q       <= disps_d;
            leds_q        <= leds_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign disps        = disps_q;
    assign digital_leds = leds_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - scoreboard bench for seg_scan_display
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        show = 1'b1;
    logic [15:0] digit_data = 16'h0000;
    logic [3:0]  digit_valid = 4'h0;
    logic [3:0]  blink_mask = 4'h0;
    logic [3:0]  dp_mask = 4'h0;
    logic [7:0]  disps;
    logic [7:0]  digital_leds;
    logic        frame_start;

    typedef struct packed {
        logic [7:0] leds;
        logic [7:0] en;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         fidx     = 0;
    logic [7:0] hex_tab [16] = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07,
                                 8'h7f, 8'h6f, 8'h77, 8'h7c, 8'h39, 8'h5e, 8'h79, 8'h71};

    seg_scan_display #(
        .NUM_DIGITS(4), .DISP_WIDTH(8), .CLK_DIV_PERIOD(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .show(show), .digit_data(digit_data), .digit_valid(digit_valid),
        .blink_mask(blink_mask), .dp_mask(dp_mask), .disps(disps),
        .digital_leds(digital_leds), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_disps"}, disps, 8'hFF);
        chk({tag, "_leds"}, digital_leds, 8'h00);
        chk({tag, "_fs"}, {7'b0, frame_start}, 8'h00);
    endtask

    // Expected per-slot results for the next frame; blink phase is dark in frames 2,3 of every 4.
    task automatic push_frame();
        exp_t e;
        logic [3:0] nib;
        logic       dark;
        dark = (fidx % 4) >= 2;
        for (int i = 0; i < 4; i++) begin
            nib = digit_data[4*i +: 4];
            if (!digit_valid[i]) e.leds = 8'h00;
            else e.leds = (show ? hex_tab[nib] : 8'h40) | {dp_mask[i], 7'b0};
            e.en = (digit_valid[i] && !(blink_mask[i] && dark)) ? ~(8'h01 << i) : 8'hFF;
            sb_q.push_back(e);
        end
        fidx++;
    endtask

    task automatic run_frame(input int chg_nib, input bit rst_mid);
        exp_t e;
        push_frame();
        for (int s = 0; s < 4; s++) begin
            e = sb_q.pop_front();
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                chk($sformatf("f%0d_s%0d_c%0d_leds", fidx - 1, s, c), digital_leds, e.leds);
                chk($sformatf("f%0d_s%0d_c%0d_disps", fidx - 1, s, c), disps, (c == 0) ? 8'hFF : e.en);
                chk($sformatf("f%0d_s%0d_c%0d_fs", fidx - 1, s, c), {7'b0, frame_start},
                    {7'b0, (c == 0 && s == 0)});
                if (chg_nib >= 0 && s == 0 && c == 1) digit_data[3:0] = 4'(chg_nib);
                if (rst_mid && s == 2 && c == 1) begin
                    rst = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle($sformatf("rst_hold%0d", i));
        end
        rst = 1'b0;
        sb_q.delete();
        fidx = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle($sformatf("post_rst%0d", i));
        end
    endtask

    initial begin
        do_reset();

        show = 1'b1; digit_data = 16'h4321; digit_valid = 4'hF;
        run_frame(-1, 1'b0);
        run_frame(-1, 1'b0);

        show = 1'b0; digit_valid = 4'b0101;
        run_frame(-1, 1'b0);
        run_frame(-1, 1'b0);

        show = 1'b1; digit_valid = 4'hF; blink_mask = 4'b0001; dp_mask = 4'b0010;
        for (int f = 0; f < 4; f++) run_frame(-1, 1'b0);

        run_frame(9, 1'b0);
        run_frame(-1, 1'b0);

        run_frame(-1, 1'b1);
        @(negedge clk);
        chk_idle("mid_rst");
        do_reset();

        blink_mask = 4'h0; dp_mask = 4'b1000; digit_data = 16'hFA5C;
        run_frame(-1, 1'b0);
        run_frame(-1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
